// File: rtl/ppgen_skid_12b.sv
// rtl/ppgen_skid_12b.sv - registered 12x12 partial-product generator with 2-entry skid buffer
module ppgen_skid_12b #(
    parameter int W     = 12,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*W-1:0]       out_pp,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_zero,
    output logic [15:0]          txn_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t               occ;
    logic [W*W-1:0]     new_pp;
    logic               new_zero;
    logic [W*W-1:0]     skid_pp;
    logic [TAG_W-1:0]   skid_tag;
    logic               skid_zero;
    logic               in_fire;
    logic               out_fire;

    // Row i of the AND array is in_a gated by bit i of in_b.
    always_comb begin
        new_pp = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                new_pp[W*i+j] = in_a[j] & in_b[i];
            end
        end
    end

    assign new_zero = (in_a == '0) | (in_b == '0);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // in_ready and out_valid are registered alongside occupancy so neither
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pp    <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
            skid_pp   <= '0;
            skid_tag  <= '0;
            skid_zero <= 1'b0;
            txn_cnt   <= 16'd0;
        end else begin
            if (out_fire) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
            case (occ)
                EMPTY: begin
                    if (in_fire) begin
                        out_pp    <= new_pp;
                        out_tag   <= in_tag;
                        out_zero  <= new_zero;
                        out_valid <= 1'b1;
                        occ       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_pp   <= new_pp;
                        skid_tag  <= in_tag;
                        skid_zero <= new_zero;
                        in_ready  <= 1'b0;
                        occ       <= TWO;
                    end else if (in_fire) begin
                        out_pp    <= new_pp;
                        out_tag   <= in_tag;
                        out_zero  <= new_zero;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        occ       <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        out_pp    <= skid_pp;
                        out_tag   <= skid_tag;
                        out_zero  <= skid_zero;
                        in_ready  <= 1'b1;
                        occ       <= ONE;
                    end
                end
                default: begin
                    occ       <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ppgen_skid_12b.md
Name: ppgen_skid_12b

Overview:
- Registered partial-product generator for the 12x12 unsigned approximate Wallace multiplier.
- Sits directly upstream of the partial-product compression tree (144-bit pp in, 24-bit res out).
- Accepts operand pairs over a valid/ready handshake and forms the 12x12 AND array.
- Holds results in a 2-entry skid buffer (output register plus skid register), so the combinational compressor sees a registered, stable pp vector under backpressure.

Parameters:
- W, 12, operand width; only 12 is supported, because the downstream tree is fixed at 144 pp bits.
- TAG_W, 4, width of the sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  12  multiplicand
- in_b  input  12  multiplier
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  pp vector valid
- out_ready  input  1  downstream accepts pp vector
- out_pp  output  144  partial products; row i = out_pp[12*i+:12], bit j = in_a[j] & in_b[i]
- out_tag  output  TAG_W  tag of the current out_pp
- out_zero  output  1  set when either operand of the current entry was zero
- txn_cnt  output  16  count of completed output handshakes, wraps modulo 2^16

Behaviour:
- Reset (rst_n low, async assert, sync-release assumed by the system):
  - out_valid=0, out_pp=0, out_tag=0, out_zero=0, txn_cnt=0.
  - Skid entry empty; in_ready=1 from the first clock after release.
- Handshake rules:
  - Input transfer when in_valid & in_ready at a rising clk edge.
  - Output transfer when out_valid & out_ready at a rising clk edge.
  - out_pp, out_tag and out_zero stay stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts without a transfer.
- PP formation: combinational AND array on the accepted operands. The result is captured into the output register, or into the skid register if the output register is occupied and not draining that cycle.
- out_zero is computed at capture as (in_a==0)|(in_b==0) and stored with the entry.
- Latency: an input accepted when the buffer is empty appears on out_valid the next cycle (1-cycle latency).
- Throughput: 1 pair/cycle while out_ready=1.
- State (encoded by occupancy: EMPTY, ONE, TWO):
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output transfer together -> stay ONE; the new entry loads the output register.
    - Input transfer only -> TWO; the new entry goes to the skid register.
    - Output transfer only -> EMPTY.
  - TWO: in_ready=0, out_valid=1.
    - Output transfer -> ONE; the skid entry moves to the output register the same edge.
    - Input is ignored.
- in_ready is a register output: in_ready = !TWO, with no combinational path from out_ready.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- txn_cnt increments on each output transfer and wraps 16'hFFFF -> 0.
- Reset mid-operation: all entries are discarded immediately and no out_valid pulse follows. txn_cnt clears.
- in_valid while in_ready=0 has no effect; the upstream holds its data.

Test Plan:
- in_a=12'hFFF, in_b=12'h001, out_ready=1 -> next cycle out_valid=1, out_pp[11:0]=12'hFFF, out_pp[143:12]=0, out_zero=0, txn_cnt=1 after the transfer.
- in_a=12'h0A5, in_b=12'h003, tag=4'h7 -> rows 0 and 1 = 12'h0A5, all other rows 0, out_tag=4'h7. in_a=12'h123, in_b=0 -> out_pp=0, out_zero=1.
- Backpressure: out_ready=0, present pairs (1,1), (2,1), (3,1) back-to-back.
  - in_ready drops after the 2nd pair is accepted; the 3rd pair is held by the upstream.
  - Release out_ready -> outputs appear in order with row0 = 1, 2, 3 and no loss or duplicates.
- Streaming with in_valid=1 and out_ready=1 for 100 random pairs -> one result per cycle after 1-cycle latency. Every out_pp bit equals a[j]&b[i], and txn_cnt=100.
- Assert rst_n low while in state TWO -> out_valid=0 and txn_cnt=0 immediately, in_ready=1 after release, no stale entry emitted.
- Preload txn_cnt via 65535 transfers, then 1 more transfer -> txn_cnt=0.
